// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift a byte out on device clocks, check ACK.
// Optional automatic resend on NACK or timeout when PS2_TX_RESEND_EN is defined.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5600,
   parameter int TIMEOUT_CYCLES = 840000,
   parameter int FILTER_LEN     = 8,
   parameter int RETRIES        = 2
) (
   input  logic       clk_56m,
   input  logic       nRESET,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_error,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe
);

   localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int FLT_W = $clog2(FILTER_LEN + 1);
   localparam int RETRY_W = $clog2(RETRIES + 2);
`ifdef PS2_TX_RESEND_EN
   localparam int RETRY_LIMIT = RETRIES;
`else
   localparam int RETRY_LIMIT = 0;
`endif

   localparam logic [INH_W-1:0]   INH_LAST   = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [FLT_W-1:0]   FLT_LAST   = FLT_W'(FILTER_LEN - 1);
   localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(RETRY_LIMIT);

   typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SHIFT, WAIT_IDLE, FAIL} state_t;

   // Index 0 carries the clock pin, index 1 the data pin.
   logic [1:0]       meta;
   logic [1:0]       sync;
   logic [1:0]       filt;
   logic [FLT_W-1:0] fcnt [2];
   logic             fclk_fall;

   state_t           state;
   logic [7:0]       data_q;
   logic             parity_q;
   logic [3:0]       bitcnt;
   logic [INH_W-1:0] inh_cnt;
   logic [TO_W-1:0]  to_cnt;
   logic [RETRY_W-1:0] retry_cnt;
   logic             timed;
   logic             timeout_hit;

   assign timed       = (state == RTS) || (state == SHIFT) || (state == WAIT_IDLE);
   assign timeout_hit = timed && (to_cnt == TO_LAST);

   // A filtered level only follows the pin after FILTER_LEN consecutive differing samples.
   always_ff @(posedge clk_56m) begin
      if (!nRESET) begin
         meta      <= 2'b11;
         sync      <= 2'b11;
         filt      <= 2'b11;
         fcnt[0]   <= '0;
         fcnt[1]   <= '0;
         fclk_fall <= 1'b0;
      end else begin
         meta      <= {ps2_dat_in, ps2_clk_in};
         sync      <= meta;
         fclk_fall <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            if (sync[i] == filt[i]) begin
               fcnt[i] <= '0;
            end else if (fcnt[i] == FLT_LAST) begin
               fcnt[i] <= '0;
               filt[i] <= sync[i];
               if (i == 0 && !sync[i]) fclk_fall <= 1'b1;
            end else begin
               fcnt[i] <= fcnt[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_56m) begin
      if (!nRESET) begin
         state      <= IDLE;
         data_q     <= '0;
         parity_q   <= 1'b0;
         bitcnt     <= '0;
         inh_cnt    <= '0;
         to_cnt     <= '0;
         retry_cnt  <= '0;
         tx_busy    <= 1'b0;
         tx_done    <= 1'b0;
         tx_error   <= 1'b0;
         ps2_clk_oe <= 1'b0;
         ps2_dat_oe <= 1'b0;
      end else begin
         tx_done  <= 1'b0;
         tx_error <= 1'b0;
         if (timed && !timeout_hit) to_cnt <= to_cnt + 1'b1;

         case (state)
            IDLE: begin
               // A pulse cycle still shows busy, so a start there is ignored.
               tx_busy <= 1'b0;
               if (tx_start && !tx_busy) begin
                  data_q     <= tx_data;
                  parity_q   <= ~^tx_data;
                  retry_cnt  <= '0;
                  inh_cnt    <= '0;
                  ps2_clk_oe <= 1'b1;
                  tx_busy    <= 1'b1;
                  state      <= INHIBIT;
               end
            end

            INHIBIT: begin
               if (inh_cnt == INH_LAST) begin
                  ps2_clk_oe <= 1'b0;
                  ps2_dat_oe <= 1'b1;
                  to_cnt     <= TO_W'(1);
                  state      <= RTS;
               end else begin
                  inh_cnt <= inh_cnt + 1'b1;
               end
            end

            RTS: begin
               if (timeout_hit) begin
                  ps2_clk_oe <= 1'b0;
                  ps2_dat_oe <= 1'b0;
                  state      <= FAIL;
               end else begin
                  bitcnt <= '0;
                  state  <= SHIFT;
               end
            end

            SHIFT: begin
               if (timeout_hit) begin
                  ps2_clk_oe <= 1'b0;
                  ps2_dat_oe <= 1'b0;
                  state      <= FAIL;
               end else if (fclk_fall) begin
                  bitcnt <= bitcnt + 1'b1;
                  if (bitcnt < 4'd8) begin
                     ps2_dat_oe <= ~data_q[bitcnt[2:0]];
                  end else if (bitcnt == 4'd8) begin
                     ps2_dat_oe <= ~parity_q;
                  end else if (bitcnt == 4'd9) begin
                     ps2_dat_oe <= 1'b0;
                  end else begin
                     ps2_clk_oe <= 1'b0;
                     ps2_dat_oe <= 1'b0;
                     state      <= filt[1] ? FAIL : WAIT_IDLE;
                  end
               end
            end

            WAIT_IDLE: begin
               if (timeout_hit) begin
                  ps2_clk_oe <= 1'b0;
                  ps2_dat_oe <= 1'b0;
                  state      <= FAIL;
               end else if (filt[0] && filt[1]) begin
                  tx_done <= 1'b1;
                  state   <= IDLE;
               end
            end

            FAIL: begin
               // With resend disabled RETRY_LAST is zero and the error path is taken at once.
               ps2_dat_oe <= 1'b0;
               if (retry_cnt != RETRY_LAST) begin
                  retry_cnt  <= retry_cnt + 1'b1;
                  inh_cnt    <= '0;
                  ps2_clk_oe <= 1'b1;
                  state      <= INHIBIT;
               end else begin
                  ps2_clk_oe <= 1'b0;
                  tx_error   <= 1'b1;
                  state      <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a bus-functional keyboard on the open-collector lines.
// Honours PS2_TX_RESEND_EN to expect the resend behaviour.
module tb_ps2_host_tx;

   localparam int INHIBIT_CYCLES = 600;
   localparam int TIMEOUT_CYCLES = 3000;
   localparam int FILTER_LEN     = 8;
   localparam int RETRIES        = 2;
   localparam int HALF           = 40;
`ifdef PS2_TX_RESEND_EN
   localparam int ATTEMPTS = RETRIES + 1;
`else
   localparam int ATTEMPTS = 1;
`endif

   logic       clk_56m = 1'b0;
   logic       nRESET = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_start = 1'b0;
   logic       tx_busy, tx_done, tx_error;
   logic       ps2_clk_oe, ps2_dat_oe;
   logic       dev_clk_low = 1'b0;
   logic       dev_dat_low = 1'b0;
   logic       clk_line, dat_line;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int done_cnt = 0, err_cnt = 0, inhibit_cnt = 0, inh_bad = 0;
   int inh_len = 0, last_inh_len = 0, rts_cyc = 0, err_cyc = 0;
   bit mon_en = 1'b0;
   logic prev_clk_oe = 1'b0, prev_pulse = 1'b0;

   assign clk_line = !(ps2_clk_oe || dev_clk_low);
   assign dat_line = !(ps2_dat_oe || dev_dat_low);

   ps2_host_tx #(
      .INHIBIT_CYCLES(INHIBIT_CYCLES),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .FILTER_LEN(FILTER_LEN),
      .RETRIES(RETRIES)
   ) dut (
      .clk_56m(clk_56m),
      .nRESET(nRESET),
      .tx_data(tx_data),
      .tx_start(tx_start),
      .tx_busy(tx_busy),
      .tx_done(tx_done),
      .tx_error(tx_error),
      .ps2_clk_in(clk_line),
      .ps2_dat_in(dat_line),
      .ps2_clk_oe(ps2_clk_oe),
      .ps2_dat_oe(ps2_dat_oe)
   );

   always #5 clk_56m = ~clk_56m;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1);
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   // The frame as it must appear on the data line: start, LSB-first byte, odd parity, stop.
   function automatic logic [10:0] modelFrame(input logic [7:0] b);
      logic p;
      p = ($countones(b) % 2) == 0;
      return {1'b1, p, b, 1'b0};
   endfunction

   // Rules that hold on every cycle once reset has settled, plus event bookkeeping.
   always @(negedge clk_56m) begin
      cyc++;
      if (mon_en) begin
         checkOutput("pulse_exclusive", 32'(tx_done & tx_error), 0);
         checkOutput("oe_exclusive", 32'(ps2_clk_oe & ps2_dat_oe), 0);
         checkOutput("idle_released", 32'(!tx_busy & (ps2_clk_oe | ps2_dat_oe)), 0);
         if (prev_pulse) checkOutput("after_pulse", {29'd0, tx_busy, tx_done, tx_error}, 0);
         if (ps2_clk_oe && !prev_clk_oe) begin
            inhibit_cnt++;
            inh_len = 0;
         end
         if (ps2_clk_oe) inh_len++;
         if (!ps2_clk_oe && prev_clk_oe) begin
            if (inh_len != INHIBIT_CYCLES) inh_bad++;
            last_inh_len = inh_len;
            if (ps2_dat_oe) rts_cyc = cyc;
         end
         if (tx_done) done_cnt++;
         if (tx_error) begin
            err_cnt++;
            err_cyc = cyc;
         end
         prev_clk_oe = ps2_clk_oe;
         prev_pulse  = tx_done | tx_error;
      end
   end

   task automatic applyStimulus(input logic [7:0] d);
      int n;
      n = 0;
      while (tx_busy && n < 20000) begin
         @(negedge clk_56m);
         n++;
      end
      tx_data  = d;
      tx_start = 1'b1;
      @(negedge clk_56m);
      tx_start = 1'b0;
   endtask

   // Keyboard side of one host-to-device frame; samples the line on each rising edge.
   task automatic kbFrame(input bit nack, input int glitch_fall, input int start_fall,
                          input int abort_fall, output logic [10:0] bits, output bit ok);
      int n;
      ok   = 1'b0;
      bits = '0;
      n    = 0;
      while (!(ps2_dat_oe && !ps2_clk_oe) && n < 10000) begin
         @(negedge clk_56m);
         n++;
      end
      if (n >= 10000) return;
      repeat (HALF) @(negedge clk_56m);
      bits[0] = dat_line;
      for (int i = 1; i <= 11; i++) begin
         if (i == 11) begin
            dev_dat_low = !nack;
            repeat (HALF / 2) @(negedge clk_56m);
         end
         dev_clk_low = 1'b1;
         repeat (HALF) @(negedge clk_56m);
         if (i == abort_fall) begin
            checkOutput("pre_reset_busy", 32'(tx_busy), 1);
            nRESET = 1'b0;
            @(negedge clk_56m);
            checkOutput("reset_lines", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
            checkOutput("reset_status", {29'd0, tx_busy, tx_done, tx_error}, 0);
            dev_clk_low = 1'b0;
            repeat (3) @(negedge clk_56m);
            nRESET = 1'b1;
            ok = 1'b1;
            return;
         end
         if (i == start_fall) begin
            tx_data  = 8'h3C;
            tx_start = 1'b1;
            @(negedge clk_56m);
            tx_start = 1'b0;
         end
         dev_clk_low = 1'b0;
         if (i <= 10) bits[i] = dat_line;
         if (i == glitch_fall) begin
            repeat (10) @(negedge clk_56m);
            dev_clk_low = 1'b1;
            repeat (5) @(negedge clk_56m);
            dev_clk_low = 1'b0;
         end
         if (i < 11) repeat (HALF) @(negedge clk_56m);
      end
      repeat (5) @(negedge clk_56m);
      dev_dat_low = 1'b0;
      ok = 1'b1;
   endtask

   task automatic waitEnd(input int base, input int budget, input string name);
      int n;
      n = 0;
      while (done_cnt + err_cnt == base && n < budget) begin
         @(negedge clk_56m);
         n++;
      end
      checkOutput(name, 32'(done_cnt + err_cnt != base), 1);
      repeat (3) @(negedge clk_56m);
   endtask

   task automatic ackFrame(input string name, input logic [7:0] d, input int glitch_fall,
                           input int start_fall, output logic [10:0] bits);
      int base, d0, e0;
      bit ok;
      base = done_cnt + err_cnt;
      d0   = done_cnt;
      e0   = err_cnt;
      applyStimulus(d);
      kbFrame(1'b0, glitch_fall, start_fall, 0, bits, ok);
      checkOutput({name, "_started"}, 32'(ok), 1);
      checkOutput({name, "_model"}, 32'(bits), 32'(modelFrame(d)));
      waitEnd(base, 2000, {name, "_end"});
      checkOutput({name, "_done"}, done_cnt - d0, 1);
      checkOutput({name, "_no_error"}, err_cnt - e0, 0);
      checkOutput({name, "_inhibit_len"}, last_inh_len, INHIBIT_CYCLES);
   endtask

   initial begin
      logic [10:0] bits;
      bit ok;
      int base, d0, e0, i0;

      repeat (5) @(negedge clk_56m);
      checkOutput("reset_state", {27'd0, tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe}, 0);
      mon_en = 1'b1;
      nRESET = 1'b1;
      repeat (20) @(negedge clk_56m);

      ackFrame("ed", 8'hED, 0, 0, bits);
      checkOutput("ed_literal", 32'(bits), 32'h7DA);
      ackFrame("x01", 8'h01, 0, 0, bits);
      checkOutput("x01_literal", 32'(bits), 32'h402);
      ackFrame("x00", 8'h00, 0, 0, bits);
      checkOutput("x00_literal", 32'(bits), 32'h600);

      // NACK on every attempt.
      base = done_cnt + err_cnt; d0 = done_cnt; e0 = err_cnt; i0 = inhibit_cnt;
      applyStimulus(8'hFF);
      for (int a = 0; a < ATTEMPTS; a++) begin
         kbFrame(1'b1, 0, 0, 0, bits, ok);
         checkOutput("nack_attempt", 32'(ok), 1);
         checkOutput("nack_model", 32'(bits), 32'(modelFrame(8'hFF)));
      end
      waitEnd(base, 2000, "nack_end");
      checkOutput("nack_error", err_cnt - e0, 1);
      checkOutput("nack_no_done", done_cnt - d0, 0);
      checkOutput("nack_inhibits", inhibit_cnt - i0, ATTEMPTS);
      checkOutput("nack_lines", {29'd0, tx_busy, ps2_clk_oe, ps2_dat_oe}, 0);

      // Keyboard never clocks.
      base = done_cnt + err_cnt; d0 = done_cnt; e0 = err_cnt; i0 = inhibit_cnt;
      applyStimulus(8'h55);
      waitEnd(base, ATTEMPTS * (INHIBIT_CYCLES + TIMEOUT_CYCLES + 10) + 100, "timeout_end");
      checkOutput("timeout_error", err_cnt - e0, 1);
      checkOutput("timeout_no_done", done_cnt - d0, 0);
      checkOutput("timeout_latency", err_cyc - rts_cyc, TIMEOUT_CYCLES);
      checkOutput("timeout_inhibits", inhibit_cnt - i0, ATTEMPTS);
      checkOutput("timeout_lines", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);

      // Clock glitch and a second start request while shifting.
      i0 = inhibit_cnt;
      ackFrame("glitch", 8'hA5, 5, 3, bits);
      checkOutput("glitch_literal", 32'(bits), 32'h74A);
      repeat (200) @(negedge clk_56m);
      checkOutput("second_start_ignored", inhibit_cnt - i0, 1);
      checkOutput("second_start_idle", 32'(tx_busy), 0);

      // Reset after the fourth falling edge, then a clean frame.
      d0 = done_cnt; e0 = err_cnt;
      applyStimulus(8'h5A);
      kbFrame(1'b0, 0, 0, 4, bits, ok);
      checkOutput("abort_reached", 32'(ok), 1);
      repeat (100) @(negedge clk_56m);
      checkOutput("abort_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
      ackFrame("after_reset", 8'hF3, 0, 0, bits);

      checkOutput("inhibit_lengths", inh_bad, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
